// File: rtl/cpu_types_pkg.sv
// Shared datapath types used by the memory-side blocks.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/dcache_pkg.sv
// Types and geometry helpers for the direct-mapped, one-word-block data cache.
package dcache_pkg;

    import cpu_types_pkg::*;

    localparam int unsigned DCACHE_SETS   = 16;
    localparam int unsigned DCACHE_ADDR_W = 32;
    localparam int unsigned IDX_W         = $clog2(DCACHE_SETS);
    localparam int unsigned TAG_W         = DCACHE_ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        FLUSH_WB,
        FLUSHED
    } dcache_state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } dcache_frame_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Datapath-side request/response and memory-side transfer signals of the data cache.
interface dcache_responder_if;

    import cpu_types_pkg::*;

    // datapath side
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  dhit;
    word_t dmemload;
    logic  flushed;

    // memory side
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

endinterface

// File: rtl/dcache_frame_array.sv
// Frame storage: combinational read port, synchronous write port, clear-all on RST.
module dcache_frame_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS = DCACHE_SETS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [$clog2(SETS)-1:0] rd_idx,
    output dcache_frame_t           rd_frame,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] wr_idx,
    input  dcache_frame_t           wr_frame
);

    dcache_frame_t frames_q [SETS];

    assign rd_frame = frames_q[rd_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (wr_en) begin
            frames_q[wr_idx] <= wr_frame;
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache responder with halt-time flush.
// Optional hit/miss counters are built when DCACHE_HITCOUNT_EN is defined.
module dcache_responder
    import cpu_types_pkg::*;
    import dcache_pkg::*;
#(
    parameter int unsigned SETS   = DCACHE_SETS,
    parameter int unsigned ADDR_W = DCACHE_ADDR_W
) (
    input  logic               CLK,
    input  logic               RST,
    dcache_responder_if.slave  bus,
    output word_t              hit_count,
    output word_t              miss_count
);

    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS = ADDR_W - IDX_BITS - 2;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(SETS - 1);

    dcache_state_t       state_q, state_d;
    logic [IDX_BITS-1:0] flush_idx_q, flush_idx_d;

    logic [IDX_BITS-1:0] req_idx;
    logic [IDX_BITS-1:0] frame_idx;
    logic [TAG_BITS-1:0] req_tag;
    dcache_frame_t       rd_frame;
    dcache_frame_t       wr_frame;
    logic                wr_en;
    logic                req;
    logic                hit;
    logic                hit_evt;
    logic                miss_evt;

    logic  dhit, dren, dwen, flushed;
    word_t dmemload, daddr, dstore;

    logic unused_addr;
    assign unused_addr = ^bus.dmemaddr[1:0];

    assign req_idx = bus.dmemaddr[IDX_BITS+1:2];
    assign req_tag = bus.dmemaddr[ADDR_W-1:IDX_BITS+2];
    assign req     = bus.dmemREN | bus.dmemWEN;
    assign hit     = rd_frame.valid && (rd_frame.tag == req_tag);

    // Reads and writes always target the same frame: the flush cursor while flushing,
    // otherwise the frame selected by the held request address.
    assign frame_idx = (state_q == FLUSH || state_q == FLUSH_WB) ? flush_idx_q : req_idx;

    dcache_frame_array #(
        .SETS (SETS)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (frame_idx),
        .rd_frame (rd_frame),
        .wr_en    (wr_en),
        .wr_idx   (frame_idx),
        .wr_frame (wr_frame)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        wr_en       = 1'b0;
        wr_frame    = rd_frame;
        dhit        = 1'b0;
        dmemload    = '0;
        dren        = 1'b0;
        dwen        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        flushed     = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        hit_evt  = 1'b1;
                        dmemload = rd_frame.data;
                        if (bus.dmemWEN) begin
                            wr_en          = 1'b1;
                            wr_frame.dirty = 1'b1;
                            wr_frame.data  = bus.dmemstore;
                        end
                    end else begin
                        miss_evt = 1'b1;
                        state_d  = (rd_frame.valid && rd_frame.dirty) ? WB : FILL;
                    end
                end else if (bus.halt) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end
            end
            WB: begin
                dwen   = 1'b1;
                daddr  = {rd_frame.tag, req_idx, 2'b00};
                dstore = rd_frame.data;
                if (!bus.dwait) begin
                    wr_en          = 1'b1;
                    wr_frame.dirty = 1'b0;
                    state_d        = FILL;
                end
            end
            FILL: begin
                dren  = 1'b1;
                daddr = {bus.dmemaddr[ADDR_W-1:2], 2'b00};
                if (!bus.dwait) begin
                    wr_en          = 1'b1;
                    wr_frame.valid = 1'b1;
                    wr_frame.dirty = 1'b0;
                    wr_frame.tag   = req_tag;
                    wr_frame.data  = bus.dload;
                    state_d        = IDLE;
                end
            end
            FLUSH: begin
                if (rd_frame.valid && rd_frame.dirty) begin
                    state_d = FLUSH_WB;
                end else if (flush_idx_q == LAST_IDX) begin
                    state_d = FLUSHED;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                dwen   = 1'b1;
                daddr  = {rd_frame.tag, flush_idx_q, 2'b00};
                dstore = rd_frame.data;
                if (!bus.dwait) begin
                    wr_en          = 1'b1;
                    wr_frame.dirty = 1'b0;
                    if (flush_idx_q == LAST_IDX) begin
                        state_d = FLUSHED;
                    end else begin
                        flush_idx_d = flush_idx_q + 1'b1;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSHED: begin
                flushed = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dhit     = dhit;
    assign bus.dmemload = dmemload;
    assign bus.dREN     = dren;
    assign bus.dWEN     = dwen;
    assign bus.daddr    = daddr;
    assign bus.dstore   = dstore;
    assign bus.flushed  = flushed;

`ifdef DCACHE_HITCOUNT_EN
    word_t hits_q, misses_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (hit_evt && hits_q != '1) begin
                hits_q <= hits_q + 32'd1;
            end
            if (miss_evt && misses_q != '1) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign hit_count  = (state_q == FLUSHED) ? hits_q : '0;
    assign miss_count = (state_q == FLUSHED) ? misses_q : '0;
`else
    logic unused_evt;
    assign unused_evt = hit_evt | miss_evt;
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a transaction-level cache/memory model.
module tb_dcache_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_responder_if bus ();
    logic [31:0] hc, mc;

    dcache_responder dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus),
        .hit_count  (hc),
        .miss_count (mc)
    );

    int tests = 0;
    int fails = 0;

    // Model: cache contents, backing memory and event counts.
    bit          mv   [16];
    bit          md   [16];
    logic [25:0] mt   [16];
    logic [31:0] mdat [16];
    logic [31:0] mem  [logic [31:0]];
    int          m_hit, m_miss;

    // Expected outputs for the current cycle.
    bit          chk_en;
    bit          e_dhit, e_dren, e_dwen, e_flushed, e_load, e_cnt;
    logic [31:0] e_addr, e_store, e_loadval;

    // Observations of the DUT for the literal checks.
    logic [31:0] last_load;
    int          wen_cycles = 0;
    int          mem_cycles = 0;
    logic [31:0] wb_addr [$];
    logic [31:0] wb_data [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input bit dh, input bit dr, input bit dw, input bit fl,
                              input logic [31:0] ad, input logic [31:0] st);
        e_dhit    = dh;
        e_dren    = dr;
        e_dwen    = dw;
        e_flushed = fl;
        e_addr    = ad;
        e_store   = st;
        e_load    = 1'b0;
        e_cnt     = 1'b0;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dhit", 32'(bus.dhit), 32'(e_dhit));
            chk("dREN", 32'(bus.dREN), 32'(e_dren));
            chk("dWEN", 32'(bus.dWEN), 32'(e_dwen));
            chk("flushed", 32'(bus.flushed), 32'(e_flushed));
            if (e_dren || e_dwen) chk("daddr", bus.daddr, e_addr);
            if (e_dwen) chk("dstore", bus.dstore, e_store);
            if (e_load) chk("dmemload", bus.dmemload, e_loadval);
            if (e_cnt) begin
`ifdef DCACHE_HITCOUNT_EN
                chk("hit_count", hc, 32'(m_hit));
                chk("miss_count", mc, 32'(m_miss));
`else
                chk("hit_count", hc, 32'd0);
                chk("miss_count", mc, 32'd0);
`endif
            end
        end
        if (bus.dhit && bus.dmemREN && !bus.dmemWEN) last_load = bus.dmemload;
        if (bus.dREN || bus.dWEN) mem_cycles++;
        if (bus.dWEN) begin
            wen_cycles++;
            if (!bus.dwait) begin
                wb_addr.push_back(bus.daddr);
                wb_data.push_back(bus.dstore);
            end
        end
    end

    // One datapath request, held until dhit; the model decides hit/miss and the phases.
    task automatic access(input bit ren, input bit wen, input logic [31:0] a,
                          input logic [31:0] wd, input int wbw, input int flw);
        logic [3:0]  idx;
        logic [25:0] tg;
        logic [31:0] va, fd;
        idx = a[5:2];
        tg  = a[31:6];
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = a;
        bus.dmemstore = wd;
        if (!(mv[idx] && mt[idx] == tg)) begin
            m_miss++;
            expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
            step();
            if (md[idx]) begin
                va = {mt[idx], idx, 2'b00};
                for (int k = 0; k <= wbw; k++) begin
                    bus.dwait = (k < wbw);
                    expect_cyc(0, 0, 1, 0, va, mdat[idx]);
                    step();
                end
                mem[va] = mdat[idx];
                md[idx] = 1'b0;
            end
            fd = memval(a);
            for (int k = 0; k <= flw; k++) begin
                bus.dwait = (k < flw);
                bus.dload = (k < flw) ? 32'hBAD0_0000 + k : fd;
                expect_cyc(0, 1, 0, 0, a, 32'h0);
                step();
            end
            mv[idx]   = 1'b1;
            md[idx]   = 1'b0;
            mt[idx]   = tg;
            mdat[idx] = fd;
        end
        bus.dwait = 1'b1;
        bus.dload = 32'hFFFF_FFFF;
        expect_cyc(1, 0, 0, 0, 32'h0, 32'h0);
        e_load    = ren && !wen;
        e_loadval = mdat[idx];
        m_hit++;
        step();
        if (wen) begin
            mdat[idx] = wd;
            md[idx]   = 1'b1;
        end
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic flush(input int wbw);
        logic [31:0] va;
        bus.halt    = 1'b1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
            step();
            if (md[i]) begin
                va = {mt[i], 4'(i), 2'b00};
                for (int k = 0; k <= wbw; k++) begin
                    bus.dwait = (k < wbw);
                    expect_cyc(0, 0, 1, 0, va, mdat[i]);
                    step();
                end
                mem[va] = mdat[i];
                md[i]   = 1'b0;
            end
        end
        expect_cyc(0, 0, 0, 1, 32'h0, 32'h0);
        e_cnt = 1'b1;
    endtask

    initial begin
        int n;
        chk_en        = 1'b0;
        rst           = 1'b1;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = 32'h0;
        bus.dmemstore = 32'h0;
        bus.halt      = 1'b0;
        bus.dwait     = 1'b1;
        bus.dload     = 32'h0;
        mem[32'h40]   = 32'hDEAD_BEEF;
        mem[32'h80]   = 32'h8080_8080;
        model_reset();
        expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;

        chk("rst_dhit", 32'(bus.dhit), 32'h0);
        chk("rst_dREN", 32'(bus.dREN), 32'h0);
        chk("rst_dWEN", 32'(bus.dWEN), 32'h0);
        chk("rst_flushed", 32'(bus.flushed), 32'h0);
        chk("rst_daddr", bus.daddr, 32'h0);
        chk("rst_dstore", bus.dstore, 32'h0);
        chk("rst_dmemload", bus.dmemload, 32'h0);
        chk_en = 1'b1;

        // read miss into a clean frame
        access(1, 0, 32'h40, 32'h0, 0, 0);
        chk("t1_load", last_load, 32'hDEAD_BEEF);

        // write hit, then read back without memory traffic
        access(0, 1, 32'h40, 32'h1234_5678, 0, 0);
        n = mem_cycles;
        access(1, 0, 32'h40, 32'h0, 0, 0);
        chk("t2_load", last_load, 32'h1234_5678);
        chk("t2_nomem", 32'(mem_cycles - n), 32'h0);

        // dirty eviction with dwait high for 3 cycles
        n = wen_cycles;
        access(1, 0, 32'h80, 32'h0, 3, 0);
        chk("t3_wb_cycles", 32'(wen_cycles - n), 32'd4);
        chk("t3_wb_addr", wb_addr[$], 32'h40);
        chk("t3_wb_data", wb_data[$], 32'h1234_5678);
        chk("t3_load", last_load, 32'h8080_8080);

        // simultaneous REN and WEN on a hit behaves as a write
        access(1, 0, 32'h08, 32'h0, 0, 1);
        chk("t4_fill_load", last_load, 32'h5A5A_0008);
        access(1, 1, 32'h08, 32'hCAFE_F00D, 0, 0);
        access(1, 0, 32'h08, 32'h0, 0, 0);
        chk("t4_load", last_load, 32'hCAFE_F00D);

        // request pending together with halt is serviced first
        bus.halt = 1'b1;
        access(0, 1, 32'h24, 32'h0000_9999, 0, 2);

        n = wb_addr.size();
        flush(1);
        chk("flush_count", 32'(wb_addr.size() - n), 32'd2);
        chk("flush_first_addr", wb_addr[n], 32'h08);
        chk("flush_first_data", wb_data[n], 32'hCAFE_F00D);
        chk("flush_second_addr", wb_addr[n+1], 32'h24);
        chk("flush_second_data", wb_data[n+1], 32'h0000_9999);

        // requests ignored once flushed; flushed stays high
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h80;
        for (int k = 0; k < 3; k++) step();
        bus.dmemREN = 1'b0;
        step();

        // reset out of FLUSHED
        rst = 1'b1;
        step();
        rst      = 1'b0;
        bus.halt = 1'b0;
        model_reset();
        expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
        step();

        // reset while a fill is stalled
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        bus.dwait    = 1'b1;
        expect_cyc(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        expect_cyc(0, 1, 0, 0, 32'h100, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        access(1, 0, 32'h100, 32'h0, 0, 0);
        chk("t6_load", last_load, 32'h0100 ^ 32'h5A5A_0000);
        access(1, 0, 32'h08, 32'h0, 0, 0);
        chk("t6_refetch", last_load, 32'hCAFE_F00D);
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
